nco_mc_tdm: RTL

Time-multiplexed, multi-channel numerically controlled oscillator that produces quadrature sine and cosine samples for `NCH` independent channels from one shared quarter-wave sine ROM. It succeeds the single-channel NCO in the receiver front end and serves several digital down-converter lanes from one instance. It adds per-channel phase offset, frame-synchronous frequency and phase retuning, and accumulator sync. One output sample per `clken` cycle; each channel receives one slot every `NCH` cycles.

---
 rtl/nco_mc_tdm.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/nco_mc_tdm.sv
// rtl/nco_mc_tdm.sv - time-multiplexed multi-channel quadrature NCO
//
// Purpose:
//   NCH independent phase accumulators share one quarter-wave sine table.
//   One (sin, cos) sample leaves per clken cycle; channels take slots in
//   round-robin order 0..NCH-1. Increment/offset writes land in shadow
//   registers and all channels retune together at the frame boundary.
//
// Build option:
//   NCO_MC_DITHER_EN - adds a 16-bit LFSR below the ROM truncation point.
//   The accumulators are untouched; only the table address is dithered.
//   Undefined (default): pure truncation, bit-exact deterministic output.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   clken               advance enable; all pipeline state holds when low
//   cfg_we              shadow write strobe (sampled regardless of clken)
//   cfg_sel             0 = phase increment, 1 = phase offset
//   cfg_ch, cfg_data    target channel and write value
//   sync                clears accumulators and slot counter (on clken)
//   fsin_o, fcos_o      signed sine / cosine samples
//   out_ch              channel tag of the current sample
//   out_valid           one-cycle strobe per loaded sample
//
// Pipeline: stage0 phase -> stage1 quadrant/address -> stage2 table read
//           -> stage3 sign and output register (4 clken edges).

module nco_mc_tdm #(
  parameter int NCH  = 4,
  parameter int APR  = 32,
  parameter int RAW  = 10,
  parameter int MPR  = 16,
  parameter     ROMF = "nco_mc_qsin.hex"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clken,
  input  logic                   cfg_we,
  input  logic                   cfg_sel,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [APR-1:0]         cfg_data,
  input  logic                   sync,
  output logic signed [MPR-1:0]  fsin_o,
  output logic signed [MPR-1:0]  fcos_o,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic                   out_valid
);

  localparam int CHW = $clog2(NCH);
  localparam int RWL = 2 ** RAW;          // table depth
  localparam int TW  = MPR - 1;           // table word width (unsigned magnitude)
  localparam int LOW = APR - RAW - 2;     // phase bits below the truncation point
  localparam logic [CHW-1:0] LAST_SLOT = CHW'(NCH - 1);

  // --------------------------------------------------------------------------
  // Quarter-wave sine table. The words are the same image ROMF names:
  // rom[i] = round((2^(MPR-1)-1) * sin(pi/2 * (i+0.5)/2^RAW)). They are
  // evaluated at elaboration so the build carries no file dependency.
  // The half-sample offset keeps every word nonzero and makes negation
  // symmetric around the zero crossings.
  // --------------------------------------------------------------------------
  function automatic logic [TW-1:0] qsin_word(input int idx);
    real x;
    real x2;
    real s;
    real amp;
    x   = 1.5707963267948966 * (real'(idx) + 0.5) / real'(RWL);
    x2  = x * x;
    // Taylor series to x^15 in Horner form; error far below half an LSB
    s   = x * (1.0 - x2 / 6.0 * (1.0 - x2 / 20.0 * (1.0 - x2 / 42.0 *
          (1.0 - x2 / 72.0 * (1.0 - x2 / 110.0 * (1.0 - x2 / 156.0 *
          (1.0 - x2 / 210.0)))))));
    amp = real'((1 << TW) - 1);
    return TW'($rtoi(amp * s + 0.5));
  endfunction

  logic [TW-1:0] rom_w [RWL];

  for (genvar gi = 0; gi < RWL; gi++) begin : g_rom
    localparam logic [TW-1:0] WORD = qsin_word(gi);
    assign rom_w[gi] = WORD;
  end

  // --------------------------------------------------------------------------
  // Channel state
  // --------------------------------------------------------------------------
  logic [CHW-1:0] slot_q;
  logic [APR-1:0] acc_q   [NCH];
  logic [APR-1:0] inc_s_q [NCH];
  logic [APR-1:0] off_s_q [NCH];
  logic [APR-1:0] inc_a_q [NCH];
  logic [APR-1:0] off_a_q [NCH];
  logic [APR-1:0] inc_s_d [NCH];
  logic [APR-1:0] off_s_d [NCH];
  logic           commit;

  // Shadow next-state includes the write of this cycle, so a commit that
  // coincides with a write carries the new value straight through.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      inc_s_d[i] = inc_s_q[i];
      off_s_d[i] = off_s_q[i];
      if (cfg_we && (cfg_ch == CHW'(i))) begin
        if (cfg_sel) off_s_d[i] = cfg_data;
        else         inc_s_d[i] = cfg_data;
      end
    end
  end

  assign commit = clken && (slot_q == LAST_SLOT);

  // --------------------------------------------------------------------------
  // Stage 0: phase of the current slot
  // --------------------------------------------------------------------------
  logic [APR-1:0] phase_d;

`ifdef NCO_MC_DITHER_EN
  localparam int DW = (LOW < 16) ? LOW : 16;

  logic [15:0] lfsr_q;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else if (clken) begin
      if (sync) lfsr_q <= 16'hACE1;
      else      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign phase_d = acc_q[slot_q] + off_a_q[slot_q] + APR'(lfsr_q[DW-1:0]);
`else
  assign phase_d = acc_q[slot_q] + off_a_q[slot_q];
`endif

  // Only the quadrant and table address bits travel down the pipeline
  logic [RAW+1:0] phase_hi;
  logic [LOW-1:0] phase_lo;
  logic           unused_phase_lo;

  assign {phase_hi, phase_lo} = phase_d;
  assign unused_phase_lo      = ^phase_lo;

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic [RAW+1:0] s1_phase_q;
  logic [CHW-1:0] s1_ch_q;
  logic           s1_v_q;

  logic [RAW-1:0] s2_sa_q;
  logic [RAW-1:0] s2_ca_q;
  logic [1:0]     s2_quad_q;
  logic [CHW-1:0] s2_ch_q;
  logic           s2_v_q;

  logic [TW-1:0]  s3_rs_q;
  logic [TW-1:0]  s3_rc_q;
  logic [1:0]     s3_quad_q;
  logic [CHW-1:0] s3_ch_q;
  logic           s3_v_q;

  // Stage 1: odd quadrants walk the quarter wave backwards; cosine reads
  // the mirrored address, i.e. sine shifted by a quarter period.
  logic [1:0]     quad_d;
  logic [RAW-1:0] sin_addr_d;
  logic [RAW-1:0] cos_addr_d;

  assign quad_d     = s1_phase_q[RAW+1:RAW];
  assign sin_addr_d = quad_d[0] ? ~s1_phase_q[RAW-1:0] : s1_phase_q[RAW-1:0];
  assign cos_addr_d = ~sin_addr_d;

  // Stage 3: sine is negative in quadrants 2,3; cosine in quadrants 1,2
  logic [MPR-1:0] rs_ext;
  logic [MPR-1:0] rc_ext;
  logic [MPR-1:0] fsin_d;
  logic [MPR-1:0] fcos_d;

  assign rs_ext = {1'b0, s3_rs_q};
  assign rc_ext = {1'b0, s3_rc_q};
  assign fsin_d = s3_quad_q[1]                  ? (~rs_ext + 1'b1) : rs_ext;
  assign fcos_d = (s3_quad_q[1] ^ s3_quad_q[0]) ? (~rc_ext + 1'b1) : rc_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i]   <= '0;
        inc_s_q[i] <= '0;
        off_s_q[i] <= '0;
        inc_a_q[i] <= '0;
        off_a_q[i] <= '0;
      end
      s1_phase_q <= '0;
      s1_ch_q    <= '0;
      s1_v_q     <= 1'b0;
      s2_sa_q    <= '0;
      s2_ca_q    <= '0;
      s2_quad_q  <= '0;
      s2_ch_q    <= '0;
      s2_v_q     <= 1'b0;
      s3_rs_q    <= '0;
      s3_rc_q    <= '0;
      s3_quad_q  <= '0;
      s3_ch_q    <= '0;
      s3_v_q     <= 1'b0;
      fsin_o     <= '0;
      fcos_o     <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        inc_s_q[i] <= inc_s_d[i];
        off_s_q[i] <= off_s_d[i];
      end

      out_valid <= 1'b0;

      if (clken) begin
        if (commit) begin
          for (int i = 0; i < NCH; i++) begin
            inc_a_q[i] <= inc_s_d[i];
            off_a_q[i] <= off_s_d[i];
          end
        end

        // The slot presented during a sync cycle is discarded; the next
        // slot restarts at channel 0 from a cleared accumulator.
        if (sync) begin
          slot_q <= '0;
          for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
        end else begin
          slot_q         <= slot_q + 1'b1;
          acc_q[slot_q]  <= acc_q[slot_q] + inc_a_q[slot_q];
        end

        s1_phase_q <= phase_hi;
        s1_ch_q    <= slot_q;
        s1_v_q     <= ~sync;

        s2_sa_q    <= sin_addr_d;
        s2_ca_q    <= cos_addr_d;
        s2_quad_q  <= quad_d;
        s2_ch_q    <= s1_ch_q;
        s2_v_q     <= s1_v_q;

        s3_rs_q    <= rom_w[s2_sa_q];
        s3_rc_q    <= rom_w[s2_ca_q];
        s3_quad_q  <= s2_quad_q;
        s3_ch_q    <= s2_ch_q;
        s3_v_q     <= s2_v_q;

        if (s3_v_q) begin
          fsin_o <= fsin_d;
          fcos_o <= fcos_d;
          out_ch <= s3_ch_q;
        end
        out_valid <= s3_v_q;
      end
    end
  end

endmodule
